// File: rtl/act_skew_feeder_pkg.sv
// Shared types and default geometry for the activation skew feeder and the PE array top.
package act_skew_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int unsigned ROWS_DEF   = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DRAIN_DEF  = 4;

endpackage

// File: rtl/skew_delay_line.sv
// Data+valid shift register of DEPTH stages; one instance per systolic row.
module skew_delay_line #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Skews activation vectors onto the systolic array left edge and flushes the tile.
// Optional stall counter output enabled by defining ACT_SKEW_STALL_CNT_EN.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DRAIN  = DRAIN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   in_last,
    output logic [ROWS*DATA_W-1:0] x_out,
    output logic [ROWS-1:0]        x_valid,
    output logic                   busy,
    output logic                   done
`ifdef ACT_SKEW_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned FLUSH_LEN = ROWS - 1 + DRAIN;
    localparam int unsigned CNT_W     = $clog2(ROWS + DRAIN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept = in_valid & in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Flow-control outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? FLUSH : STREAM;
                    if (in_last) cnt_d = CNT_W'(FLUSH_LEN - 1);
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_LEN - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d != FLUSH);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FLUSH) && (cnt_d == '0);
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Row r gets r+1 stages; non-accepted cycles inject zero bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_W-1:0] lane_in;
        assign lane_in = accept ? in_data[r*DATA_W +: DATA_W] : '0;

        skew_delay_line #(
            .DEPTH  (r + 1),
            .DATA_W (DATA_W)
        ) u_delay (
            .clk     (clk),
            .rst     (rst),
            .data_i  (lane_in),
            .valid_i (accept),
            .data_o  (x_out[r*DATA_W +: DATA_W]),
            .valid_o (x_valid[r])
        );
    end

`ifdef ACT_SKEW_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && accept)
            stall_cnt_d = '0;
        else if (state_q == STREAM && !in_valid && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder with a per-lane timed scoreboard.
module tb_act_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int DRAIN = 4;
    localparam int FLEN  = ROWS - 1 + DRAIN;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;
    logic [ROWS*DW-1:0]   x_out;
    logic [ROWS-1:0]      x_valid;
    logic                 busy;
    logic                 done;
`ifdef ACT_SKEW_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    act_skew_feeder #(.ROWS(ROWS), .DATA_W(DW), .DRAIN(DRAIN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done)
`ifdef ACT_SKEW_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb_q [ROWS][$];
    int          tests;
    int          fails;
    int          cyc;
    int          ready_at;
    int          done_at;
    int          busy_lo;
    int          busy_hi;
    bit          streaming;
    logic [31:0] exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) sb_q[r].delete();
        ready_at  = 0;
        done_at   = -1;
        busy_lo   = 1 << 30;
        busy_hi   = -1;
        streaming = 1'b0;
        exp_stall = '0;
    endtask

    // One clock cycle: drive, check at negedge, update model, advance past posedge.
    task automatic step(input logic v, input logic [ROWS*DW-1:0] d, input logic last, output bit acc);
        bit            rdy;
        bit            act;
        logic          ev;
        logic [DW-1:0] ed;
        in_valid = v;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        rdy = (cyc >= ready_at);
        act = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("busy", 32'(busy), 32'(act));
        chk("done", 32'(done), 32'(cyc == done_at));
        for (int r = 0; r < ROWS; r++) begin
            if (sb_q[r].size() != 0 && sb_q[r][0].due == cyc) begin
                ev = 1'b1;
                ed = sb_q[r][0].data;
                void'(sb_q[r].pop_front());
            end else begin
                ev = 1'b0;
                ed = '0;
            end
            chk($sformatf("lane%0d", r), 32'({x_valid[r], x_out[r*DW +: DW]}), 32'({ev, ed}));
        end
`ifdef ACT_SKEW_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, exp_stall);
`endif
        acc = v && rdy && !rst;
        if (streaming && !v) exp_stall = exp_stall + 32'd1;
        if (acc) begin
            for (int r = 0; r < ROWS; r++)
                sb_q[r].push_back('{due: cyc + 1 + r, data: d[r*DW +: DW]});
            if (!act) begin
                busy_lo   = cyc + 1;
                busy_hi   = 1 << 30;
                exp_stall = '0;
            end
            streaming = !last;
            if (last) begin
                done_at  = cyc + FLEN;
                busy_hi  = cyc + FLEN;
                ready_at = cyc + FLEN + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
    endtask

    initial begin
        bit acc;
        int n;
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        model_reset();

        // Reset held with clock running.
        idle(3);
        rst = 1'b0;
        idle(2);

        // Single-beat tile.
        step(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, acc);
        idle(10);

        // Four back-to-back beats.
        step(1'b1, {4{8'h10}}, 1'b0, acc);
        step(1'b1, {4{8'h20}}, 1'b0, acc);
        step(1'b1, {4{8'h30}}, 1'b0, acc);
        step(1'b1, {4{8'h40}}, 1'b1, acc);
        idle(12);

        // Bubble between first and second beat.
        step(1'b1, {4{8'h11}}, 1'b0, acc);
        step(1'b0, {4{8'hEE}}, 1'b0, acc);
        step(1'b1, {4{8'h22}}, 1'b0, acc);
        step(1'b1, {4{8'h33}}, 1'b0, acc);
        step(1'b1, {4{8'h44}}, 1'b1, acc);
        idle(12);
`ifdef ACT_SKEW_STALL_CNT_EN
        chk("stall_cnt_final", stall_cnt, 32'd1);
`endif

        // Upstream beat held through FLUSH.
        step(1'b1, {4{8'h01}}, 1'b1, acc);
        n = 0;
        do begin
            step(1'b1, {4{8'hAA}}, 1'b1, acc);
            n++;
        end while (!acc && n < 20);
        chk("held_accepted", 32'(acc), 32'd1);
        chk("held_wait", 32'(n), 32'(FLEN + 1));
        idle(12);

        // Reset pulsed mid-tile.
        step(1'b1, {4{8'h51}}, 1'b0, acc);
        step(1'b1, {4{8'h52}}, 1'b0, acc);
        in_valid = 1'b1;
        in_data  = {4{8'h53}};
        rst      = 1'b1;
        #1;
        chk("rst_x_out", x_out, '0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        rst      = 1'b0;
        in_valid = 1'b0;
        model_reset();
        idle(4);

        step(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, acc);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4: systolic rows fed; one activation lane per row; ROWS >= 2.
REQ-002 Parameter DATA_W, default 8: activation width, matching the PE datapath.
REQ-003 Parameter DRAIN, default 4: extra zero cycles after skew flush, for partial-sum drain through the array columns.
REQ-004 clk  in  1: clock, rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 in_valid  in  1: in_data and in_last valid.
REQ-007 in_ready  out  1: feeder accepts a beat this cycle.
REQ-008 in_data  in  ROWS*DATA_W: activation vector; lane r = bits [r*DATA_W +: DATA_W].
REQ-009 in_last  in  1: final vector of the tile.
REQ-010 x_out  out  ROWS*DATA_W: skewed activations to array left edge; lane r drives row r.
REQ-011 x_valid  out  ROWS: per-row qualifier for x_out lane r.
REQ-012 busy  out  1: state is not IDLE.
REQ-013 done  out  1: single-cycle pulse on the last FLUSH cycle.

Function
REQ-014 States IDLE, STREAM, FLUSH; 2-bit state register.
REQ-015 Beat accepted when in_valid & in_ready; in_ready = 1 in IDLE and STREAM, 0 in FLUSH.
REQ-016 Datapath advances every cycle, with no enable; the array is free-running.
REQ-017 Row r is a delay line of r+1 registers; lane r of a beat accepted in cycle t appears on x_out lane r with x_valid[r]=1 in cycle t+1+r.
REQ-018 Cycles with no accepted beat insert zero data with valid 0 into stage 0 of every row.
REQ-019 IDLE -> STREAM on an accepted beat with in_last=0; IDLE -> FLUSH on an accepted beat with in_last=1.
REQ-020 STREAM -> FLUSH on an accepted beat with in_last=1; otherwise stay, including bubbles (in_valid=0).
REQ-021 FLUSH lasts exactly ROWS-1+DRAIN cycles, tracked by a down-counter of width $clog2(ROWS+DRAIN), loaded on FLUSH entry.
REQ-022 done=1 in the final FLUSH cycle only; IDLE in the next cycle, with in_ready=1.
REQ-023 During FLUSH, in_data and in_valid are ignored; an upstream beat is held, not lost (standard valid/ready).
REQ-024 No arithmetic on data; values pass bit-exact.

Reset
REQ-025 rst asserted: state=IDLE, all delay registers 0, x_out=0, x_valid=0, done=0, busy=0, counter=0, effective immediately.
REQ-026 Reset mid-tile discards all in-flight data; no done pulse is issued for the aborted tile.

Configuration
REQ-027 Macro ACT_SKEW_STALL_CNT_EN defined: adds output stall_cnt (32 bits), which counts STREAM cycles with in_valid=0, saturates at all-ones, clears on reset and on each IDLE -> STREAM/FLUSH transition.
REQ-028 Macro undefined: stall_cnt port and logic absent; all other behaviour is identical.

Structure
REQ-029 The shared package holds the state enum (IDLE/STREAM/FLUSH) and default ROWS/DATA_W/DRAIN constants, also used by the PE array top.
REQ-030 One sub-module, skew_delay_line (parameter DEPTH, DATA_W; data+valid shift register), is instantiated per row with DEPTH=r+1.

Verification (ROWS=4, DATA_W=8, DRAIN=4)
REQ-031 Reset held, clock running -> x_out=0, x_valid=0, in_ready=1, busy=0, done=0.
REQ-032 Cycle 0: accept {lane3..0}={4,3,2,1} with in_last=1 -> lane0=1 in cycle 1, lane1=2 in cycle 2, lane2=3 in cycle 3, lane3=4 in cycle 4; in_ready=0 in cycles 1-7; done in cycle 7; in_ready=1 in cycle 8.
REQ-033 Four back-to-back beats 0x10,0x20,0x30,0x40 (all lanes equal), in_last on the 4th -> lane r shows 0x10..0x40 in cycles 1+r..4+r; FLUSH is 7 cycles; done in cycle 10.
REQ-034 Bubble between beats 1 and 2 -> one x_valid=0 zero slot per lane at the offset cycle; with ACT_SKEW_STALL_CNT_EN, stall_cnt=1.
REQ-035 in_valid held with data 0xAA during FLUSH -> not accepted until IDLE, then accepted once; appears on lane0 the following cycle.
REQ-036 rst pulsed in cycle 2 of a 4-beat tile -> all outputs 0 immediately, no done, next tile behaves as in REQ-032.
